// File: rtl/io_input_cond.sv
`default_nettype none
// ============================================================================
// Module      : io_input_cond
// Description : Multi-channel key/switch conditioner: synchroniser, debounce,
//               polarity inversion, rise/fall pulses, sticky events, IRQ.
//               Long-press detection is built when IO_LONG_PRESS_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module io_input_cond #(
    parameter int                NUM_CH        = 4,
    parameter int                SYNC_STAGES   = 2,
    parameter int                STABLE_CYCLES = 2000000,
    parameter logic [NUM_CH-1:0] INV_MASK      = '0,
    parameter int                LONG_CYCLES   = 50000000
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [NUM_CH-1:0] i_raw,
    input  logic [NUM_CH-1:0] i_evt_clr,
    input  logic [NUM_CH-1:0] i_irq_en,
    output logic [NUM_CH-1:0] o_level,
    output logic [NUM_CH-1:0] o_rise,
    output logic [NUM_CH-1:0] o_fall,
    output logic [NUM_CH-1:0] o_evt,
    output logic              o_irq,
    output logic [NUM_CH-1:0] o_long
);

    localparam int                 C_CNT_W   = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
    localparam logic [C_CNT_W-1:0] C_CNT_MAX = C_CNT_W'(STABLE_CYCLES - 1);

    logic [SYNC_STAGES-1:0][NUM_CH-1:0] r_sync;
    logic [NUM_CH-1:0]                  w_sync;
    logic [NUM_CH-1:0]                  w_accept;
    logic [NUM_CH-1:0]                  w_rise;
    logic [NUM_CH-1:0]                  w_fall;
    logic [NUM_CH-1:0]                  r_level;
    logic [NUM_CH-1:0]                  r_rise;
    logic [NUM_CH-1:0]                  r_fall;
    logic [NUM_CH-1:0]                  r_evt;

    // Inversion ahead of the first flop, so reset value '0 means "logically idle".
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sync <= '0;
        end else begin
            r_sync[0] <= i_raw ^ INV_MASK;
            for (int s = 1; s < SYNC_STAGES; s++) begin
                r_sync[s] <= r_sync[s-1];
            end
        end
    end

    assign w_sync = r_sync[SYNC_STAGES-1];

    generate
        for (genvar g = 0; g < NUM_CH; g++) begin : g_debounce
            logic [C_CNT_W-1:0] r_cnt;

            always_ff @(posedge i_clk) begin
                if (i_rst) begin
                    r_cnt <= '0;
                end else if ((w_sync[g] == r_level[g]) || (r_cnt == C_CNT_MAX)) begin
                    r_cnt <= '0;
                end else begin
                    r_cnt <= r_cnt + C_CNT_W'(1);
                end
            end

            assign w_accept[g] = (w_sync[g] != r_level[g]) && (r_cnt == C_CNT_MAX);
        end
    endgenerate

    assign w_rise = w_accept & ~r_level;
    assign w_fall = w_accept & r_level;

    // Event is set both on the accepting edge and while o_rise is high, so a
    // clear coinciding with the rise pulse cannot swallow the event.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_level <= '0;
            r_rise  <= '0;
            r_fall  <= '0;
            r_evt   <= '0;
        end else begin
            r_level <= r_level ^ w_accept;
            r_rise  <= w_rise;
            r_fall  <= w_fall;
            r_evt   <= (r_evt & ~i_evt_clr) | w_rise | r_rise;
        end
    end

    assign o_level = r_level;
    assign o_rise  = r_rise;
    assign o_fall  = r_fall;
    assign o_evt   = r_evt;
    assign o_irq   = |(r_evt & i_irq_en);

`ifdef IO_LONG_PRESS_EN
    localparam int                  C_HOLD_W   = (LONG_CYCLES > 1) ? $clog2(LONG_CYCLES) : 1;
    localparam logic [C_HOLD_W-1:0] C_HOLD_MAX = C_HOLD_W'(LONG_CYCLES - 1);
    localparam logic [C_HOLD_W-1:0] C_HOLD_PRE = C_HOLD_W'(LONG_CYCLES - 2);

    logic [NUM_CH-1:0] w_long;

    generate
        for (genvar g = 0; g < NUM_CH; g++) begin : g_long
            logic [C_HOLD_W-1:0] r_hold;
            logic                r_long;

            // Counter saturates at the terminal value, giving one pulse per press.
            always_ff @(posedge i_clk) begin
                if (i_rst) begin
                    r_hold <= '0;
                    r_long <= 1'b0;
                end else begin
                    r_long <= 1'b0;
                    if (!r_level[g]) begin
                        r_hold <= '0;
                    end else if (r_hold != C_HOLD_MAX) begin
                        r_hold <= r_hold + C_HOLD_W'(1);
                        if (r_hold == C_HOLD_PRE) begin
                            r_long <= 1'b1;
                        end
                    end
                end
            end

            assign w_long[g] = r_long;
        end
    endgenerate

    assign o_long = w_long;
`else
    assign o_long = '0;
`endif

endmodule
`default_nettype wire
